rotimm_encoder: RTL
===================

# rotimm_encoder

Multi-cycle encoder that converts a 32-bit constant into the data-processing rotated-immediate form (imm8, rot4) such that value = imm8 rotated right by 2·rot4. It is the inverse of the operand-2 rotate-immediate path in the shifter. The assembler/constant-loading support logic uses it to decide whether a constant fits a single MOV/ALU immediate. The search runs sequentially, one rotation per clock, behind a start/done handshake.

## Interface
- EARLY_EXIT, 1, 1: finish at the first matching rotation; 0: always scan all 16 rotations (constant latency) and report the smallest matching rot.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while idle
- value  input  32  constant to encode; sampled with start
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse when results are updated
- found  output  1  value is encodable; valid from done onward
- imm8  output  8  encoded 8-bit immediate; 0 when not found
- rot  output  4  rotate field; value = imm8 ROR (2·rot); 0 when not found

## Operation
- States: IDLE, SEARCH.
- IDLE: start=1 at a clock edge latches value into an internal register, clears the rotation counter k to 0, and moves to SEARCH. busy=1 from the next cycle.
- SEARCH, each cycle:
  - Form cand = latched value rotated LEFT by 2·k (32-bit rotate, mod 32).
  - Hit: cand[31:8]==0.
- Record rule: on the first hit, register imm8=cand[7:0] and rot=k. Later hits do not overwrite, so the smallest rot always wins.
- Exit on an edge:
  - EARLY_EXIT=1: exit on a hit or when k==15.
  - EARLY_EXIT=0: exit only when k==15.
  - Otherwise k increments.
- Exit edge:
  - found, imm8 and rot take their final values.
  - done=1 for exactly the next cycle; busy returns to 0 in that same cycle; state returns to IDLE.
  - No hit in any of the 16 rotations: found=0, imm8=0, rot=0.
- start while busy: ignored; the latched value is unaffected by changes on value during SEARCH.
- start in the done cycle: accepted, since the state is IDLE. found/imm8/rot hold until the next exit edge overwrites them.
- value==0: hit at k=0, giving found=1, imm8=0, rot=0.

## Timing
- Reset (asynchronous, any time including mid-search):
  - State goes to IDLE; busy, done, found = 0; imm8, rot = 0; k = 0.
  - The search is abandoned and no done pulse follows.
- Latency (start-accept edge at E, first hit at k=h):
  - EARLY_EXIT=1: done high in cycle E+h+1, i.e. the cycle after edge E+h+1. Range 1..16 cycles; a non-encodable value takes 16.
  - EARLY_EXIT=0: done always in the cycle after edge E+16.
- Throughput: one search per (latency+1) cycles at most. Back-to-back operation by re-asserting start in the done cycle gives zero idle gap.
- busy is high from the cycle after accept through the last SEARCH cycle, and is never high together with done.
- Combinational path per cycle is one 32-bit rotate plus a 24-bit zero check. No combinational path runs from inputs to outputs.

## Test plan
- Reset mid-search:
  - Stimulus: start, value=0x00000101; assert reset at cycle 5.
  - Response: busy, done, found, imm8, rot all 0 immediately. No done pulse afterwards. A new start then completes normally.
- Simple encodable value (EARLY_EXIT=1):
  - Stimulus: value=0x000000FF.
  - Response: done 1 cycle after accept; found=1, imm8=0xFF, rot=0.
- Rotated encodable values (EARLY_EXIT=1):
  - value=0xFF000000: done 5 cycles after accept; found=1, imm8=0xFF, rot=4.
  - value=0x000003FC: done 16 cycles after accept; imm8=0xFF, rot=15.
- Non-encodable value:
  - Stimulus: value=0x00000101.
  - Response: done 16 cycles after accept; found=0, imm8=0, rot=0.
- Constant latency (EARLY_EXIT=0):
  - Stimulus: value=0xF000000F.
  - Response: done exactly 16 cycles after accept; found=1, imm8=0xFF, rot=2 (smallest match).
- Handshake:
  - start pulses and value changes during SEARCH are ignored.
  - start in the done cycle with value=0 is accepted. The second done follows 1 cycle later with found=1, imm8=0, rot=0.
  - The results of the first search hold throughout the second search.
- Randomized: 1000 random values plus shifted bytes, checked against a reference model that computes imm8 ROR 2·rot == value with minimal rot.

Source files
------------

// File: rtl/rotimm_encoder.sv
// Sequential rotated-immediate encoder: finds imm8/rot such that value == imm8 ROR (2*rot),
// testing one rotation per clock behind a start/done handshake.
module rotimm_encoder #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [7:0]  imm8,
  output logic [3:0]  rot,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] val_q;
  logic [3:0]  k;
  logic        hit_seen;
  logic [7:0]  hit_imm;
  logic [3:0]  hit_rot;

  logic [4:0]  sh;
  logic [63:0] dbl;
  logic [31:0] cand;
  logic        hit;
  logic        last;
  logic        exit_now;

  // Rotate-left by 2k: the upper half of the doubled word shifted left.
  assign sh       = {k, 1'b0};
  assign dbl      = {val_q, val_q} << sh;
  assign cand     = dbl[63:32];
  assign hit      = ~|cand[31:8];
  assign last     = (k == 4'd15);
  assign exit_now = (state == SEARCH) && (last || ((EARLY_EXIT == 1'b1) && hit));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake: start is sampled only in IDLE (including the done cycle); done is a
  // one-cycle pulse after the exit edge and never overlaps busy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (exit_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SEARCH);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q    <= '0;
      k        <= '0;
      hit_seen <= 1'b0;
      hit_imm  <= '0;
      hit_rot  <= '0;
      done     <= 1'b0;
      found    <= 1'b0;
      imm8     <= '0;
      rot      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            val_q    <= value;
            k        <= '0;
            hit_seen <= 1'b0;
            hit_imm  <= '0;
            hit_rot  <= '0;
          end
        end
        SEARCH: begin
          // Only the first hit is recorded so the smallest rotation wins.
          if (hit && !hit_seen) begin
            hit_seen <= 1'b1;
            hit_imm  <= cand[7:0];
            hit_rot  <= k;
          end
          if (exit_now) begin
            done  <= 1'b1;
            found <= hit_seen | hit;
            if (hit_seen) begin
              imm8 <= hit_imm;
              rot  <= hit_rot;
            end else if (hit) begin
              imm8 <= cand[7:0];
              rot  <= k;
            end else begin
              imm8 <= '0;
              rot  <= '0;
            end
          end else begin
            k <= k + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
